// File: rtl/fv_bank_req_arbiter_pkg.sv
// Shared types and sizing for the FV bank request arbiter: FSM state encoding,
// default read timeout and the request packet sent to the FV bank controller.
package fv_bank_req_arbiter_pkg;

  localparam int NUM_EDGE_PE    = 4;
  localparam int MAX_NODE_ID    = 256;
  localparam int NODE_W         = $clog2(MAX_NODE_ID);
  localparam int FV_BANDWIDTH   = 64;
  localparam int PE_TAG_W       = $clog2(NUM_EDGE_PE);
  localparam int RD_TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT_RD = 2'd1,
    ARB_WB      = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                    valid;
    logic                    rd_wr;
    logic                    wr_eos;
    logic [PE_TAG_W-1:0]     PE_tag;
    logic [NODE_W-1:0]       Node_id;
    logic [FV_BANDWIDTH-1:0] data;
  } Req2Output_SRAM_Bank;

endpackage

// File: rtl/fv_bank_req_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping.
// Produces both the one-hot grant and its index.
module fv_bank_req_arbiter_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      idx = sum[IW-1:0];
      if (!any_o && req_i[idx]) begin
        any_o         = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = idx;
      end
    end
  end

endmodule

// File: rtl/fv_bank_req_arbiter.sv
// Arbitrates the FV bank between Edge PE reads (round-robin) and writebacks,
// yielding the bank entirely while iteration streaming owns it.
module fv_bank_req_arbiter
  import fv_bank_req_arbiter_pkg::*;
#(
  parameter  int NUM_RD     = NUM_EDGE_PE,
  parameter  int RD_TIMEOUT = RD_TIMEOUT_DEF,
  localparam int IDX_W      = (NUM_RD > 1) ? $clog2(NUM_RD) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stream_mode,
  input  logic [NUM_RD-1:0]             rd_req_valid,
  input  logic [NUM_RD-1:0][NODE_W-1:0] rd_req_node_id,
  output logic [NUM_RD-1:0]             rd_req_ready,
  input  logic                          wb_valid,
  input  logic [NODE_W-1:0]             wb_node_id,
  input  logic [FV_BANDWIDTH-1:0]       wb_data,
  input  logic                          wb_eos,
  output logic                          wb_ready,
  input  logic                          rd_done,
  output Req2Output_SRAM_Bank           req_pkt,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy,
  output logic                          err
);

  localparam int TMR_W = ($clog2(RD_TIMEOUT) > 0) ? $clog2(RD_TIMEOUT) : 1;

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              last_wb_q, last_wb_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [NODE_W-1:0] node_q, node_d;
  logic [IDX_W-1:0]  gid_q, gid_d;
  logic              err_q, err_d;

  logic [NUM_RD-1:0] pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              rd_any;
  logic              grant_rd;
  logic              grant_wb;

  fv_bank_req_arbiter_rr_pick #(
    .N (NUM_RD)
  ) u_rr_pick (
    .req_i     (rd_req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .any_o     (rd_any)
  );

  // A writeback normally wins, but right after a WB grant pending reads go first.
  always_comb begin
    grant_rd = 1'b0;
    grant_wb = 1'b0;
    if (state_q == ARB_IDLE && !stream_mode) begin
      if (wb_valid && !(last_wb_q && rd_any)) begin
        grant_wb = 1'b1;
      end else if (rd_any) begin
        grant_rd = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    last_wb_d = last_wb_q;
    timer_d   = timer_q;
    node_d    = node_q;
    gid_d     = gid_q;
    err_d     = err_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_wb) begin
          last_wb_d = 1'b1;
          node_d    = wb_node_id;
          if (!wb_eos) begin
            state_d = ARB_WB;
          end
        end else if (grant_rd) begin
          last_wb_d = 1'b0;
          gid_d     = pick_idx;
          node_d    = rd_req_node_id[pick_idx];
          rr_ptr_d  = (pick_idx == IDX_W'(NUM_RD - 1)) ? '0 : pick_idx + IDX_W'(1);
          timer_d   = TMR_W'(1);
          state_d   = ARB_WAIT_RD;
        end
      end
      ARB_WAIT_RD: begin
        if (rd_done) begin
          timer_d = '0;
          state_d = ARB_IDLE;
        end else if (timer_q >= TMR_W'(RD_TIMEOUT - 1)) begin
          // Timer holds cycles elapsed since the grant; give up and flag it.
          timer_d = '0;
          err_d   = 1'b1;
          state_d = ARB_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ARB_WB: begin
        if (!wb_valid) begin
          err_d = 1'b1;
        end
        if (wb_eos) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      last_wb_q <= 1'b0;
      timer_q   <= '0;
      node_q    <= '0;
      gid_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      last_wb_q <= last_wb_d;
      timer_q   <= timer_d;
      node_q    <= node_d;
      gid_q     <= gid_d;
      err_q     <= err_d;
    end
  end

  // Grants are presented in the same cycle they are decided.
  always_comb begin
    req_pkt      = '0;
    rd_req_ready = '0;
    wb_ready     = 1'b0;
    grant_id     = gid_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_wb) begin
          req_pkt.valid   = 1'b1;
          req_pkt.rd_wr   = 1'b1;
          req_pkt.Node_id = wb_node_id;
          req_pkt.data    = wb_data;
          req_pkt.wr_eos  = wb_eos;
          wb_ready        = 1'b1;
        end else if (grant_rd) begin
          req_pkt.valid   = 1'b1;
          req_pkt.PE_tag  = PE_TAG_W'(pick_idx);
          req_pkt.Node_id = rd_req_node_id[pick_idx];
          rd_req_ready    = pick_oh;
          grant_id        = pick_idx;
        end
      end
      ARB_WAIT_RD: begin
        req_pkt.PE_tag  = PE_TAG_W'(gid_q);
        req_pkt.Node_id = node_q;
      end
      ARB_WB: begin
        req_pkt.valid   = 1'b1;
        req_pkt.rd_wr   = 1'b1;
        req_pkt.Node_id = node_q;
        req_pkt.data    = wb_data;
        req_pkt.wr_eos  = wb_eos;
        wb_ready        = 1'b1;
      end
      default: begin
        req_pkt = '0;
      end
    endcase
    if (reset) begin
      req_pkt      = '0;
      rd_req_ready = '0;
      wb_ready     = 1'b0;
      grant_id     = '0;
    end
  end

  assign busy = !reset && (state_q != ARB_IDLE);
  assign err  = !reset && err_q;

endmodule

// File: tb/tb_fv_bank_req_arbiter.sv
// Bench for fv_bank_req_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_fv_bank_req_arbiter;
  import fv_bank_req_arbiter_pkg::*;

  localparam int NRD = 4;
  localparam int TMO = 64;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       stream_mode;
  logic [NRD-1:0]             rd_req_valid;
  logic [NRD-1:0][NODE_W-1:0] rd_req_node_id;
  logic [NRD-1:0]             rd_req_ready;
  logic                       wb_valid;
  logic [NODE_W-1:0]          wb_node_id;
  logic [FV_BANDWIDTH-1:0]    wb_data;
  logic                       wb_eos;
  logic                       wb_ready;
  logic                       rd_done;
  Req2Output_SRAM_Bank        req_pkt;
  logic [1:0]                 grant_id;
  logic                       busy;
  logic                       err;

  fv_bank_req_arbiter #(
    .NUM_RD     (NRD),
    .RD_TIMEOUT (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stream_mode    (stream_mode),
    .rd_req_valid   (rd_req_valid),
    .rd_req_node_id (rd_req_node_id),
    .rd_req_ready   (rd_req_ready),
    .wb_valid       (wb_valid),
    .wb_node_id     (wb_node_id),
    .wb_data        (wb_data),
    .wb_eos         (wb_eos),
    .wb_ready       (wb_ready),
    .rd_done        (rd_done),
    .req_pkt        (req_pkt),
    .grant_id       (grant_id),
    .busy           (busy),
    .err            (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: what the bank is doing, at transaction level.
  int                m_mode;     // 0 free, 1 read outstanding, 2 writeback burst
  int                m_ptr;
  bit                m_prev_wb;
  bit                m_err;
  logic [NODE_W-1:0] m_node;
  int                m_gid;
  int                m_gstart;

  logic [NRD-1:0]      s_ready, last_ready;
  logic                s_wbr, last_wbr, s_busy, s_err;
  logic [1:0]          s_gid;
  Req2Output_SRAM_Bank s_pkt;

  int wb_left;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    logic [NRD-1:0]      e_ready;
    logic                e_wbr, e_busy, e_err;
    logic [1:0]          e_gid, wx;
    Req2Output_SRAM_Bank e_pkt;
    int                  win;
    bit                  rd_pend, g_rd, g_wb;
    @(negedge clk);
    win = -1;
    for (int k = 0; k < NRD; k++) begin
      if (win < 0 && rd_req_valid[2'((m_ptr + k) % NRD)]) win = (m_ptr + k) % NRD;
    end
    wx      = 2'(win);
    rd_pend = (rd_req_valid != '0);
    g_rd    = 1'b0;
    g_wb    = 1'b0;
    if (m_mode == 0 && !stream_mode) begin
      if (wb_valid && !(m_prev_wb && rd_pend)) g_wb = 1'b1;
      else if (rd_pend) g_rd = 1'b1;
    end
    e_ready = '0;
    e_wbr   = 1'b0;
    e_pkt   = '0;
    e_gid   = 2'(m_gid);
    e_busy  = (m_mode != 0);
    e_err   = m_err;
    if (g_wb || m_mode == 2) begin
      e_pkt.valid   = 1'b1;
      e_pkt.rd_wr   = 1'b1;
      e_pkt.Node_id = g_wb ? wb_node_id : m_node;
      e_pkt.data    = wb_data;
      e_pkt.wr_eos  = wb_eos;
      e_wbr         = 1'b1;
    end
    if (g_rd) begin
      e_pkt.valid   = 1'b1;
      e_pkt.PE_tag  = wx;
      e_pkt.Node_id = rd_req_node_id[wx];
      e_ready       = 4'b0001 << wx;
      e_gid         = wx;
    end
    if (m_mode == 1) begin
      e_pkt.PE_tag  = 2'(m_gid);
      e_pkt.Node_id = m_node;
    end
    if (reset) begin
      e_ready = '0; e_wbr = 1'b0; e_pkt = '0; e_gid = '0; e_busy = 1'b0; e_err = 1'b0;
    end
    s_ready = rd_req_ready; s_wbr = wb_ready; s_pkt = req_pkt;
    s_gid = grant_id; s_busy = busy; s_err = err;
    chk("rd_req_ready", 128'(s_ready), 128'(e_ready));
    chk("wb_ready",     128'(s_wbr),   128'(e_wbr));
    chk("req_pkt",      128'(s_pkt),   128'(e_pkt));
    chk("grant_id",     128'(s_gid),   128'(e_gid));
    chk("busy",         128'(s_busy),  128'(e_busy));
    chk("err",          128'(s_err),   128'(e_err));
    if (reset) begin
      m_mode = 0; m_ptr = 0; m_prev_wb = 1'b0; m_err = 1'b0; m_node = '0; m_gid = 0;
    end else if (m_mode == 0) begin
      if (g_wb) begin
        m_prev_wb = 1'b1;
        m_node    = wb_node_id;
        if (!wb_eos) m_mode = 2;
      end else if (g_rd) begin
        m_prev_wb = 1'b0;
        m_gid     = win;
        m_node    = rd_req_node_id[wx];
        m_ptr     = (win + 1) % NRD;
        m_gstart  = cyc;
        m_mode    = 1;
      end
    end else if (m_mode == 1) begin
      if (rd_done) m_mode = 0;
      else if (cyc - m_gstart == TMO - 1) begin
        m_mode = 0;
        m_err  = 1'b1;
      end
    end else begin
      if (!wb_valid) m_err = 1'b1;
      if (wb_eos) m_mode = 0;
    end
    last_ready = e_ready;
    last_wbr   = e_wbr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; stream_mode = 1'b0; rd_req_valid = '0; wb_valid = 1'b0; wb_eos = 1'b0;
    rd_done = 1'b0; wb_data = '0; wb_node_id = '0; rd_req_node_id = '0; wb_left = 0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    m_mode = 0; m_ptr = 0; m_prev_wb = 1'b0; m_err = 1'b0; m_node = '0; m_gid = 0; m_gstart = 0;
    reset = 1'b1; stream_mode = 1'b0; rd_req_valid = '0; rd_req_node_id = '0; wb_valid = 1'b0;
    wb_node_id = '0; wb_data = '0; wb_eos = 1'b0; rd_done = 1'b0; wb_left = 0;
    @(posedge clk);
    #1;

    // Two simultaneous reads, round-robin from 0, pointer ends past PE2.
    do_reset();
    rd_req_node_id[0] = 8'h11; rd_req_node_id[2] = 8'h22; rd_req_valid = 4'b0101;
    step();
    chk("t38_first_ready", 128'(s_ready), 128'(4'b0001));
    chk("t38_first_node", 128'(s_pkt.Node_id), 128'(8'h11));
    rd_req_valid = 4'b0100; rd_done = 1'b1;
    step();
    chk("t38_wait_busy", 128'(s_busy), 128'(1'b1));
    rd_done = 1'b0;
    step();
    chk("t38_second_ready", 128'(s_ready), 128'(4'b0100));
    chk("t38_second_gid", 128'(s_gid), 128'(2'd2));
    rd_req_valid = 4'b0000; rd_done = 1'b1;
    step();
    rd_done = 1'b0; rd_req_valid = 4'b1001;
    step();
    chk("t38_ptr_at_3", 128'(s_ready), 128'(4'b1000));

    // Three-beat writeback ahead of a pending PE1 read.
    do_reset();
    rd_req_valid = 4'b0010; rd_req_node_id[1] = 8'h33;
    wb_valid = 1'b1; wb_node_id = 8'h44; wb_data = 64'hA1; wb_eos = 1'b0;
    step();
    chk("t39_beat1_wbr", 128'(s_wbr), 128'(1'b1));
    chk("t39_beat1_ready", 128'(s_ready), 128'(4'b0000));
    wb_node_id = 8'h55; wb_data = 64'hA2;
    step();
    chk("t39_beat2_node", 128'(s_pkt.Node_id), 128'(8'h44));
    wb_data = 64'hA3; wb_eos = 1'b1;
    step();
    chk("t39_beat3_eos", 128'(s_pkt.wr_eos), 128'(1'b1));
    wb_valid = 1'b0; wb_eos = 1'b0;
    step();
    chk("t39_pe1_after", 128'(s_ready), 128'(4'b0010));

    // Streaming blocks every grant; releasing it lets the writeback go first.
    do_reset();
    stream_mode = 1'b1; rd_req_valid = 4'b1111; wb_valid = 1'b1; wb_eos = 1'b1; wb_node_id = 8'h66;
    repeat (3) begin
      step();
      chk("t40_blocked_ready", 128'(s_ready), 128'(4'b0000));
      chk("t40_blocked_wb", 128'(s_wbr), 128'(1'b0));
    end
    stream_mode = 1'b0;
    step();
    chk("t40_wb_first", 128'(s_wbr), 128'(1'b1));

    // Read timeout.
    do_reset();
    rd_req_valid = 4'b0010;
    step();
    chk("t41_grant", 128'(s_ready), 128'(4'b0010));
    rd_req_valid = 4'b0000;
    for (int i = 1; i < TMO; i++) step();
    chk("t41_busy_last", 128'(s_busy), 128'(1'b1));
    chk("t41_err_before", 128'(s_err), 128'(1'b0));
    rd_req_valid = 4'b1000;
    step();
    chk("t41_idle", 128'(s_busy), 128'(1'b0));
    chk("t41_err", 128'(s_err), 128'(1'b1));
    chk("t41_next_served", 128'(s_ready), 128'(4'b1000));

    // Single-beat writeback stays free; the pending read wins next.
    do_reset();
    rd_req_valid = 4'b0001; wb_valid = 1'b1; wb_eos = 1'b1;
    step();
    chk("t42_wb", 128'(s_wbr), 128'(1'b1));
    step();
    chk("t42_read_next", 128'(s_ready), 128'(4'b0001));

    // Missing writeback beat flags an error but is still forwarded.
    do_reset();
    wb_valid = 1'b1; wb_eos = 1'b0;
    step();
    wb_valid = 1'b0;
    step();
    chk("t29_forwarded", 128'(s_pkt.valid), 128'(1'b1));
    wb_valid = 1'b1; wb_eos = 1'b1;
    step();
    chk("t29_err", 128'(s_err), 128'(1'b1));

    // Reset in the middle of a read.
    do_reset();
    rd_req_valid = 4'b0100;
    step();
    rd_req_valid = 4'b0000;
    step();
    chk("t43_busy_before", 128'(s_busy), 128'(1'b1));
    reset = 1'b1; rd_req_valid = 4'b1001;
    step();
    chk("t43_rst_ready", 128'(s_ready), 128'(4'b0000));
    chk("t43_rst_busy", 128'(s_busy), 128'(1'b0));
    reset = 1'b0;
    step();
    chk("t43_ptr_zero", 128'(s_ready), 128'(4'b0001));

    // Random traffic.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NRD; i++) begin
        logic [1:0] ix;
        ix = 2'(i);
        if (rd_req_valid[ix] && last_ready[ix]) rd_req_valid[ix] = 1'b0;
        if (!rd_req_valid[ix] && $urandom_range(0, 3) == 0) begin
          rd_req_valid[ix]   = 1'b1;
          rd_req_node_id[ix] = NODE_W'($urandom);
        end
      end
      if (wb_valid && last_wbr) begin
        if (wb_eos) begin
          wb_valid = 1'b0;
          wb_eos   = 1'b0;
        end else begin
          wb_left--;
          wb_data = {$urandom, $urandom};
          wb_eos  = (wb_left == 1);
        end
      end
      if (!wb_valid && $urandom_range(0, 4) == 0) begin
        wb_left    = $urandom_range(1, 4);
        wb_valid   = 1'b1;
        wb_node_id = NODE_W'($urandom);
        wb_data    = {$urandom, $urandom};
        wb_eos     = (wb_left == 1);
      end
      rd_done = (m_mode == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) stream_mode = ~stream_mode;
      reset = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
